// File: rtl/nlf_enum_pkg.sv
// Shared types and constants for the non-linear-function input enumerator.
package nlf_enum_pkg;

  // Crypto1 filter truth tables; fa/fb are the 4-input lookups used by crapto1's filter().
  localparam logic [31:0] CRYPTO1_FC = 32'hEC57_E80A;
  localparam logic [15:0] CRYPTO1_FA = 16'hF22C;
  localparam logic [15:0] CRYPTO1_FB = 16'hD938;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 256; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/nlf_enum_lsb_pri_enc.sv
// Lowest-set-bit priority encoder: index, one-hot form and single-bit flag.
module lsb_pri_enc #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]         vec_i,
  output logic [$clog2(W)-1:0] idx_o,
  output logic [W-1:0]         onehot_o,
  output logic                 single_o
);

  localparam int unsigned IW = $clog2(W);

  always_comb begin
    idx_o    = '0;
    onehot_o = vec_i & (~vec_i + W'(1));
    single_o = (vec_i != '0) && ((vec_i & (vec_i - W'(1))) == '0);
    // Scan downward so the lowest set bit wins.
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/nlf_enum.sv
// Streams, in ascending order, every input vector of an NIN-input function FN
// whose output equals the requested bit, then pulses DONE with the match count.
module nlf_enum
  import nlf_enum_pkg::*;
#(
  parameter int unsigned NIN = 5,
  parameter              FN  = CRYPTO1_FC,
  localparam int unsigned CW = NIN + 1
) (
  input  logic           CLK,
  input  logic           RESETn,
  input  logic           REQ_VALID,
  output logic           REQ_READY,
  input  logic           REQ_BIT,
  input  logic           ABORT,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [NIN-1:0] OUT_DATA,
  output logic           OUT_LAST,
  output logic           DONE,
  output logic [CW-1:0]  MATCH_CNT
);

  localparam int unsigned W = 2 ** NIN;
  localparam logic [W-1:0] FN_W = W'(FN);

  if ($bits(FN) != W) begin : g_fn_width
    $error("nlf_enum: FN is %0d bits, expected 2**NIN = %0d", $bits(FN), W);
  end

  state_e         state_q, state_d;
  logic [W-1:0]   pend_q, pend_d;
  logic [W-1:0]   onehot_q, onehot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NIN-1:0] out_data_q, out_data_d;
  logic           req_ready_q, req_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;

  logic [NIN-1:0] enc_idx;
  logic [W-1:0]   enc_onehot;
  logic           enc_single;

  // Encode the next pending set so the beat presented next cycle comes straight from flops.
  lsb_pri_enc #(.W(W)) u_enc (
    .vec_i    (pend_d),
    .idx_o    (enc_idx),
    .onehot_o (enc_onehot),
    .single_o (enc_single)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          pend_d  = REQ_BIT ? FN_W : ~FN_W;
          cnt_d   = '0;
          state_d = (pend_d != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (out_valid_q && OUT_READY) begin
          pend_d = pend_q & ~onehot_q;
          cnt_d  = cnt_q + CW'(1);
          if (out_last_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a beat handshaked this cycle.
    if (ABORT) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      cnt_d   = cnt_q;
    end
    req_ready_d = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    out_data_d  = enc_idx;
    out_last_d  = enc_single;
    onehot_d    = enc_onehot;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      onehot_q    <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      onehot_q    <= onehot_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LAST  = out_last_q;
  assign DONE      = done_q;
  assign MATCH_CNT = cnt_q;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RESETn && out_valid_q) begin
      assert (out_last_q == (popcount(256'(pend_q)) == 1))
        else $error("nlf_enum: OUT_LAST disagrees with remaining pending set");
    end
  end
`endif

endmodule

// File: tb/tb_nlf_enum.sv
// Bench for nlf_enum: four instances (Fc, all-0, all-1, 4-input) against a queue-based model.
module tb_nlf_enum;
  import nlf_enum_pkg::*;

  localparam int unsigned NI = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] req_valid, req_bit, abort, out_ready;
  logic [NI-1:0] req_ready, out_valid, out_last, done;
  logic [4:0] od0, od1, od2;
  logic [3:0] od3;
  logic [5:0] mc0, mc1, mc2;
  logic [4:0] mc3;
  logic [4:0] out_data  [NI];
  logic [5:0] match_cnt [NI];

  always_comb begin
    out_data[0]  = od0;
    out_data[1]  = od1;
    out_data[2]  = od2;
    out_data[3]  = {1'b0, od3};
    match_cnt[0] = mc0;
    match_cnt[1] = mc1;
    match_cnt[2] = mc2;
    match_cnt[3] = {1'b0, mc3};
  end

  nlf_enum #(.NIN(5), .FN(CRYPTO1_FC)) u_fc (
    .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_BIT(req_bit[0]), .ABORT(abort[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
    .OUT_DATA(od0), .OUT_LAST(out_last[0]), .DONE(done[0]), .MATCH_CNT(mc0));
  nlf_enum #(.NIN(5), .FN(32'h0000_0000)) u_zero (
    .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_BIT(req_bit[1]), .ABORT(abort[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
    .OUT_DATA(od1), .OUT_LAST(out_last[1]), .DONE(done[1]), .MATCH_CNT(mc1));
  nlf_enum #(.NIN(5), .FN(32'hFFFF_FFFF)) u_ones (
    .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[2]), .REQ_READY(req_ready[2]),
    .REQ_BIT(req_bit[2]), .ABORT(abort[2]), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]),
    .OUT_DATA(od2), .OUT_LAST(out_last[2]), .DONE(done[2]), .MATCH_CNT(mc2));
  nlf_enum #(.NIN(4), .FN(16'h8001)) u_n4 (
    .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[3]), .REQ_READY(req_ready[3]),
    .REQ_BIT(req_bit[3]), .ABORT(abort[3]), .OUT_VALID(out_valid[3]), .OUT_READY(out_ready[3]),
    .OUT_DATA(od3), .OUT_LAST(out_last[3]), .DONE(done[3]), .MATCH_CNT(mc3));

  int n_err = 0;
  int n_checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: list of matching vectors built from the truth table, consumed one per handshake.
  logic [31:0] m_fn  [NI];
  int          m_nin [NI];
  int          m_list[NI][32];
  int          m_head[NI], m_tail[NI], m_cnt[NI];
  bit          m_done[NI];

  task automatic model_step();
    for (int m = 0; m < int'(NI); m++) begin
      if (!rst_n) begin
        m_head[m] = 0; m_tail[m] = 0; m_cnt[m] = 0; m_done[m] = 1'b0;
      end else if (abort[m]) begin
        m_head[m] = 0; m_tail[m] = 0; m_done[m] = 1'b0;
      end else if (m_done[m]) begin
        m_done[m] = 1'b0;
      end else if (m_head[m] < m_tail[m]) begin
        if (out_ready[m]) begin
          m_head[m]++;
          m_cnt[m]++;
          if (m_head[m] == m_tail[m]) m_done[m] = 1'b1;
        end
      end else if (req_valid[m]) begin
        m_head[m] = 0; m_tail[m] = 0; m_cnt[m] = 0;
        for (int i = 0; i < (1 << m_nin[m]); i++) begin
          if (m_fn[m][i] == req_bit[m]) begin
            m_list[m][m_tail[m]] = i;
            m_tail[m]++;
          end
        end
        if (m_tail[m] == 0) m_done[m] = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_on) begin
      for (int m = 0; m < int'(NI); m++) begin
        bit busy;
        busy = (m_head[m] < m_tail[m]);
        chk($sformatf("req_ready[%0d]", m), 64'(req_ready[m]), 64'(!busy && !m_done[m]));
        chk($sformatf("out_valid[%0d]", m), 64'(out_valid[m]), 64'(busy));
        chk($sformatf("done[%0d]", m), 64'(done[m]), 64'(m_done[m]));
        chk($sformatf("match_cnt[%0d]", m), 64'(match_cnt[m]), 64'(m_cnt[m]));
        if (busy) begin
          chk($sformatf("out_data[%0d]", m), 64'(out_data[m]), 64'(m_list[m][m_head[m]]));
          chk($sformatf("out_last[%0d]", m), 64'(out_last[m]), 64'(m_head[m] == m_tail[m] - 1));
        end
      end
    end
  end

  int cap[64];
  int cap_n, cap_cyc;

  // Issue one request on instance m from a negedge; returns at the negedge showing DONE (or after abort).
  task automatic run_one(input int m, input logic b, input int unsigned pct, input int ab);
    int g;
    cap_n = 0;
    req_valid[m] = 1'b1; req_bit[m] = b; out_ready[m] = 1'b1; abort[m] = 1'b0;
    g = 0;
    while (!req_ready[m] && g < 50) begin @(negedge clk); g++; end
    chk($sformatf("accept_wait[%0d]", m), 64'(g < 50), 64'(1));
    @(negedge clk);
    req_valid[m] = 1'b0;
    g = 0;
    while (!done[m] && g < 300) begin
      out_ready[m] = ($urandom_range(99) < pct);
      abort[m] = (ab >= 0) && (cap_n == ab) && out_valid[m];
      if (abort[m]) out_ready[m] = 1'b1;
      if (out_valid[m] && out_ready[m] && !abort[m]) begin
        cap[cap_n] = int'(out_data[m]);
        cap_n++;
      end
      @(negedge clk);
      g++;
      if (abort[m]) begin abort[m] = 1'b0; break; end
    end
    out_ready[m] = 1'b0;
    cap_cyc = g;
    chk($sformatf("timeout[%0d]", m), 64'(g < 300), 64'(1));
  endtask

  logic [31:0] mask0, mask1;
  int          first_n4[2];
  int          dups;

  initial begin
    m_fn[0] = CRYPTO1_FC;    m_nin[0] = 5;
    m_fn[1] = 32'h0;         m_nin[1] = 5;
    m_fn[2] = 32'hFFFF_FFFF; m_nin[2] = 5;
    m_fn[3] = 32'h0000_8001; m_nin[3] = 4;
    req_valid = '0; req_bit = '0; abort = '0; out_ready = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < int'(NI); m++) begin
      chk($sformatf("rst_ready[%0d]", m), 64'(req_ready[m]), 64'(1));
      chk($sformatf("rst_valid[%0d]", m), 64'(out_valid[m]), 64'(0));
      chk($sformatf("rst_cnt[%0d]", m), 64'(match_cnt[m]), 64'(0));
    end
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Fc, bit 1, no backpressure: known sequence 1,3,11,...,31.
    run_one(0, 1'b1, 100, -1);
    chk("fc1_beats", 64'(cap_n), 64'(16));
    chk("fc1_v0", 64'(cap[0]), 64'(1));
    chk("fc1_v1", 64'(cap[1]), 64'(3));
    chk("fc1_v2", 64'(cap[2]), 64'(11));
    chk("fc1_v3", 64'(cap[3]), 64'(13));
    chk("fc1_v15", 64'(cap[15]), 64'(31));
    chk("fc1_cycles", 64'(cap_cyc), 64'(16));
    chk("fc1_done", 64'(done[0]), 64'(1));
    chk("fc1_cnt", 64'(match_cnt[0]), 64'(16));
    mask1 = '0;
    for (int i = 0; i < cap_n; i++) mask1[cap[i]] = 1'b1;

    // Fc, bit 0, random stalls: complementary set, ascending, disjoint.
    @(negedge clk);
    run_one(0, 1'b0, 60, -1);
    chk("fc0_beats", 64'(cap_n), 64'(16));
    chk("fc0_cnt", 64'(match_cnt[0]), 64'(16));
    chk("fc0_v0", 64'(cap[0]), 64'(0));
    mask0 = '0;
    dups = 0;
    for (int i = 0; i < cap_n; i++) begin
      if (i > 0 && cap[i] <= cap[i-1]) dups++;
      mask0[cap[i]] = 1'b1;
    end
    chk("fc0_ascending", 64'(dups), 64'(0));
    chk("union_full", 64'(mask0 | mask1), 64'(32'hFFFF_FFFF));
    chk("union_disjoint", 64'(mask0 & mask1), 64'(0));

    // Abort with a 4th beat pending.
    @(negedge clk);
    run_one(0, 1'b1, 100, 3);
    chk("abort_cnt", 64'(match_cnt[0]), 64'(3));
    chk("abort_nodone", 64'(done[0]), 64'(0));
    chk("abort_ready", 64'(req_ready[0]), 64'(1));
    chk("abort_novalid", 64'(out_valid[0]), 64'(0));
    run_one(0, 1'b1, 100, -1);
    chk("restart_v0", 64'(cap[0]), 64'(1));
    chk("restart_beats", 64'(cap_n), 64'(16));

    // Empty set.
    @(negedge clk);
    run_one(1, 1'b1, 100, -1);
    chk("empty_beats", 64'(cap_n), 64'(0));
    chk("empty_cycles", 64'(cap_cyc), 64'(0));
    chk("empty_cnt", 64'(match_cnt[1]), 64'(0));

    // Full set with stalls.
    @(negedge clk);
    run_one(2, 1'b1, 70, -1);
    chk("full_beats", 64'(cap_n), 64'(32));
    chk("full_last", 64'(cap[31]), 64'(31));
    chk("full_cnt", 64'(match_cnt[2]), 64'(32));

    // NIN=4, back-to-back requests give identical results.
    @(negedge clk);
    run_one(3, 1'b1, 100, -1);
    chk("n4_beats", 64'(cap_n), 64'(2));
    chk("n4_v0", 64'(cap[0]), 64'(0));
    chk("n4_v1", 64'(cap[1]), 64'(15));
    chk("n4_cnt", 64'(match_cnt[3]), 64'(2));
    first_n4[0] = cap[0];
    first_n4[1] = cap[1];
    run_one(3, 1'b1, 100, -1);
    chk("n4_repeat_v0", 64'(cap[0]), 64'(first_n4[0]));
    chk("n4_repeat_v1", 64'(cap[1]), 64'(first_n4[1]));
    chk("n4_popcnt", 64'(match_cnt[3]), 64'(popcount(256'(m_fn[3][15:0]))));

    // Random traffic on all instances, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < int'(NI); m++) begin
        req_valid[m] = 1'($urandom_range(1));
        req_bit[m]   = 1'($urandom_range(1));
        out_ready[m] = ($urandom_range(9) < 7);
        abort[m]     = ($urandom_range(39) == 0);
      end
      @(negedge clk);
    end
    req_valid = '0; abort = '0; out_ready = '0;
    repeat (40) @(negedge clk);
    out_ready = '1;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    req_valid[0] = 1'b1; req_bit[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid[0]), 64'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int m = 0; m < int'(NI); m++) begin
      chk($sformatf("arst_ready[%0d]", m), 64'(req_ready[m]), 64'(1));
      chk($sformatf("arst_valid[%0d]", m), 64'(out_valid[m]), 64'(0));
      chk($sformatf("arst_last[%0d]", m), 64'(out_last[m]), 64'(0));
      chk($sformatf("arst_done[%0d]", m), 64'(done[m]), 64'(0));
      chk($sformatf("arst_data[%0d]", m), 64'(out_data[m]), 64'(0));
      chk($sformatf("arst_cnt[%0d]", m), 64'(match_cnt[m]), 64'(0));
    end
    out_ready = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 64'(req_ready[0]), 64'(1));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/nlf_enum.md
Name: nlf_enum

Overview:
- Parametrised successor to the Crypto1 Fc enumerator.
- Given a requested output bit, streams every input vector of an NIN-input non-linear function (truth table FN) that produces that bit.
- Outputs one matching vector per accepted beat, in ascending order, with a last flag and a final match count.
- Feeds the state-recovery search engines, replacing the fixed 5-input Fc-only enumerator with one instance per filter function (fa/fb/fc).

Parameters:
NIN, 5, number of function inputs (2..8)
FN, 32'hEC57E80A, truth table of width 2**NIN; bit i = f(i)
CW, NIN+1, localparam: match-count width

Ports:
CLK  in  1  clock
RESETn  in  1  asynchronous active-low reset
REQ_VALID  in  1  enumeration request valid
REQ_READY  out  1  block can accept a request
REQ_BIT  in  1  target function output bit
ABORT  in  1  cancel current enumeration
OUT_VALID  out  1  OUT_DATA holds a matching vector
OUT_READY  in  1  downstream accepts the vector
OUT_DATA  out  NIN  matching input vector
OUT_LAST  out  1  current vector is the final match
DONE  out  1  one-cycle pulse: enumeration finished
MATCH_CNT  out  CW  number of vectors emitted in the last enumeration

Behaviour:
- One clock CLK; reset RESETn is asynchronous, active-low.
- Reset values: state IDLE, pend mask 0, REQ_READY=1, OUT_VALID=0, OUT_LAST=0, DONE=0, MATCH_CNT=0, OUT_DATA=0.
- FSM states:
  - IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY: pend <= REQ_BIT ? FN : ~FN (width 2**NIN), MATCH_CNT <= 0. Next state is RUN if pend≠0, else DONE.
  - RUN: REQ_READY=0, OUT_VALID=1.
    - OUT_DATA = index of the lowest set bit of pend.
    - OUT_LAST = (pend & (pend-1))==0.
    - On OUT_VALID&&OUT_READY: clear that bit, MATCH_CNT++. If OUT_LAST, next state is DONE.
    - Without OUT_READY: all outputs hold stable (AXI-style; no retraction).
  - DONE: DONE=1 for exactly one cycle, OUT_VALID=0; next state is IDLE. MATCH_CNT holds until the next accepted request.
- Timing:
  - Latency: first OUT_VALID in the cycle after request acceptance.
  - Throughput: one vector per cycle while OUT_READY=1.
  - Full enumeration of k matches takes k+2 cycles from accept to IDLE with no backpressure.
- Outputs are driven only from registered state. There is no combinational path from OUT_READY or REQ_VALID to any output.
- Empty set (FN all-0 with REQ_BIT=1, or all-1 with REQ_BIT=0): no OUT_VALID; DONE pulses the cycle after accept; MATCH_CNT=0.
- Full set: 2**NIN vectors, 0..2**NIN-1; MATCH_CNT=2**NIN (hence CW=NIN+1).
- ABORT has priority over every other event in any state:
  - Next state is IDLE and pend is cleared.
  - No DONE pulse; MATCH_CNT keeps the value reached at that point.
  - A beat handshaked in the same cycle as ABORT is not counted.
- ABORT in IDLE together with REQ_VALID: the request is not accepted.
- REQ_VALID in RUN/DONE: ignored (REQ_READY=0); the requester holds it.
- Reset mid-operation: immediate return to reset values; no DONE.
- Elaboration check: $bits(FN)==2**NIN, otherwise $error.

Decomposition:
- Package nlf_enum_pkg:
  - Crypto1 filter truth-table constants (CRYPTO1_FC=32'hEC57E80A, plus the 4-input fa/fb tables).
  - State enum typedef (IDLE/RUN/DONE).
  - Function popcount() used by the bench and by assertions.
- One natural sub-module: lsb_pri_enc, parametrised on width W. It takes a W-bit vector and produces the lowest-set-bit index, a one-hot form, and an "exactly one bit set" flag. nlf_enum instantiates it on pend.

Test Plan:
- Default FN, REQ_BIT=1, OUT_READY=1 -> OUT_DATA 1,3,11,13,14,15,…,29,30,31 on consecutive cycles; OUT_LAST only on 31; 16 beats; DONE one cycle later; MATCH_CNT=16.
- Default FN, REQ_BIT=0, random OUT_READY stalls -> 0,2,4,… ascending. OUT_DATA/OUT_LAST stable across each stall; 16 beats; union with the REQ_BIT=1 set covers 0..31 exactly once.
- ABORT asserted after the 3rd handshake (a 4th beat pending) -> IDLE next cycle, no DONE, MATCH_CNT=3; a new request is accepted the following cycle and restarts from vector 1.
- FN=32'h0, REQ_BIT=1 -> no OUT_VALID; DONE in the cycle after accept; MATCH_CNT=0. FN=32'hFFFFFFFF, REQ_BIT=1 -> 32 beats, MATCH_CNT=32.
- NIN=4, FN=16'h8001, REQ_BIT=1 -> beats 0 then 15 (OUT_LAST); MATCH_CNT=2. Back-to-back requests -> REQ_READY low through RUN/DONE; second enumeration is identical.
- RESETn deasserted asynchronously mid-RUN (between clock edges) -> all outputs return to reset values immediately; REQ_READY=1 after release.
